// File: rtl/multi_debouncer.sv
// N-channel pushbutton conditioner: 2-FF synchroniser, prescaled sliding-window
// majority vote with hysteresis, press/release pulses and a long-press flag.
module multi_debouncer #(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned WIN        = 10,
  parameter int unsigned HI_TH      = 7,
  parameter int unsigned LO_TH      = 3,
  parameter int unsigned SAMPLE_DIV = 1,
  parameter int unsigned HOLD_TICKS = 500
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] button,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] btn_rise,
  output logic [N_CH-1:0] btn_fall,
  output logic [N_CH-1:0] btn_held
);

  localparam int unsigned CW = $clog2(WIN + 1);
  localparam int unsigned DW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned HW = $clog2(HOLD_TICKS + 1);

  logic [N_CH-1:0] sync1_q, sync2_q;
  logic [DW-1:0]   div_q, div_d;
  logic            tick_c;

  // Shared sample-tick prescaler
  always_comb begin
    tick_c = (div_q == DW'(SAMPLE_DIV - 1));
    div_d  = tick_c ? '0 : div_q + DW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      div_q   <= '0;
    end else begin
      sync1_q <= button;
      sync2_q <= sync1_q;
      div_q   <= div_d;
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [WIN-1:0] win_q, win_d, win_n;
    logic [CW-1:0]  cnt_c;
    logic [HW-1:0]  hold_q, hold_d;
    logic           level_q, level_d;
    logic           rise_q, rise_d;
    logic           fall_q, fall_d;
    logic           held_q, held_d;

    // Window vote; the window is reloaded on a transition so the next flip needs a full run
    always_comb begin
      win_n = {win_q[WIN-2:0], sync2_q[c]};
      cnt_c = '0;
      for (int unsigned b = 0; b < WIN; b++) begin
        cnt_c = cnt_c + CW'(win_n[b]);
      end

      win_d   = win_q;
      level_d = level_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      if (tick_c) begin
        if (!level_q && (cnt_c >= CW'(HI_TH))) begin
          level_d = 1'b1;
          rise_d  = 1'b1;
          win_d   = '1;
        end else if (level_q && (cnt_c <= CW'(LO_TH))) begin
          level_d = 1'b0;
          fall_d  = 1'b1;
          win_d   = '0;
        end else begin
          win_d = win_n;
        end
      end

      // Hold time counts ticks after the rising tick, so it starts from zero on a press
      hold_d = hold_q;
      if (!level_d) begin
        hold_d = '0;
      end else if (tick_c && level_q && (hold_q != HW'(HOLD_TICKS))) begin
        hold_d = hold_q + HW'(1);
      end
      held_d = (hold_d == HW'(HOLD_TICKS));
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        win_q   <= '0;
        hold_q  <= '0;
        level_q <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
        held_q  <= 1'b0;
      end else begin
        win_q   <= win_d;
        hold_q  <= hold_d;
        level_q <= level_d;
        rise_q  <= rise_d;
        fall_q  <= fall_d;
        held_q  <= held_d;
      end
    end

    assign btn_level[c] = level_q;
    assign btn_rise[c]  = rise_q;
    assign btn_fall[c]  = fall_q;
    assign btn_held[c]  = held_q;
  end

endmodule

// File: tb/tb_multi_debouncer.sv
// Bench for multi_debouncer: two instances (default and divided/short-hold), a queue
// scoreboard fed by a window/majority reference model, plus directed latency checks.
module tb_multi_debouncer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] button = 4'h0;

  logic [3:0] lvl0, rise0, fall0, held0;
  logic [3:0] lvl1, rise1, fall1, held1;

  always #5 clk = ~clk;

  multi_debouncer u_dut0 (
    .clk(clk), .rst_n(rst_n), .button(button),
    .btn_level(lvl0), .btn_rise(rise0), .btn_fall(fall0), .btn_held(held0)
  );

  multi_debouncer #(.SAMPLE_DIV(4), .HOLD_TICKS(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .button(button),
    .btn_level(lvl1), .btn_rise(rise1), .btn_fall(fall1), .btn_held(held1)
  );

  typedef struct packed {
    logic [3:0] lvl;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] held;
  } obs_t;

  typedef struct packed {
    obs_t d1;
    obs_t d0;
  } exp_t;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp_v, $time);
    end
  endtask

  // ---------------- reference model ----------------
  localparam int WINM = 10;
  localparam int HIM  = 7;
  localparam int LOM  = 3;
  int sdiv [2] = '{1, 4};
  int hticks [2] = '{500, 16};

  exp_t       exp_q[$];
  logic [3:0] hist[$];
  int         cyc;
  int         mwin [2][4][WINM];
  bit         mlvl [2][4];
  bit         mrs  [2][4];
  bit         mfl  [2][4];
  int         mth  [2][4];

  task automatic m_reset();
    hist.delete();
    cyc = 0;
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 4; c++) begin
        for (int k = 0; k < WINM; k++) mwin[d][c][k] = 0;
        mlvl[d][c] = 0; mrs[d][c] = 0; mfl[d][c] = 0; mth[d][c] = 0;
      end
  endtask

  task automatic m_step(input logic [3:0] b);
    logic [3:0] smp;
    hist.push_back(b);
    if (hist.size() > 3) void'(hist.pop_front());
    smp = (hist.size() == 3) ? hist[0] : 4'h0;
    for (int d = 0; d < 2; d++) begin
      bit tick;
      tick = ((cyc % sdiv[d]) == sdiv[d] - 1);
      for (int c = 0; c < 4; c++) begin
        mrs[d][c] = 0;
        mfl[d][c] = 0;
        if (tick) begin
          int ones;
          bit was;
          was = mlvl[d][c];
          for (int k = 0; k < WINM - 1; k++) mwin[d][c][k] = mwin[d][c][k+1];
          mwin[d][c][WINM-1] = int'(smp[c]);
          ones = 0;
          for (int k = 0; k < WINM; k++) ones += mwin[d][c][k];
          if (!was && ones >= HIM) begin
            mlvl[d][c] = 1; mrs[d][c] = 1; mth[d][c] = 0;
            for (int k = 0; k < WINM; k++) mwin[d][c][k] = 1;
          end else if (was && ones <= LOM) begin
            mlvl[d][c] = 0; mfl[d][c] = 1; mth[d][c] = 0;
            for (int k = 0; k < WINM; k++) mwin[d][c][k] = 0;
          end else if (was && mth[d][c] < hticks[d]) begin
            mth[d][c]++;
          end
        end
      end
    end
    cyc++;
  endtask

  function automatic exp_t m_snap();
    obs_t o[2];
    exp_t e;
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 4; c++) begin
        o[d].lvl[c]  = mlvl[d][c];
        o[d].rise[c] = mrs[d][c];
        o[d].fall[c] = mfl[d][c];
        o[d].held[c] = mlvl[d][c] && (mth[d][c] >= hticks[d]);
      end
    e.d0 = o[0];
    e.d1 = o[1];
    return e;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_reset();
      exp_q.delete();
      exp_q.push_back('0);
    end else begin
      m_step(button);
      exp_q.push_back(m_snap());
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    exp_t e;
    e = '0;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    if (exp_q.size() > 0 || !rst_n || e != '0 || 1'b1) begin
      chk("sb_lvl0",  int'(lvl0),  int'(e.d0.lvl));
      chk("sb_rise0", int'(rise0), int'(e.d0.rise));
      chk("sb_fall0", int'(fall0), int'(e.d0.fall));
      chk("sb_held0", int'(held0), int'(e.d0.held));
      chk("sb_lvl1",  int'(lvl1),  int'(e.d1.lvl));
      chk("sb_rise1", int'(rise1), int'(e.d1.rise));
      chk("sb_fall1", int'(fall1), int'(e.d1.fall));
      chk("sb_held1", int'(held1), int'(e.d1.held));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] pick(input int sel);
    case (sel)
      0: return rise0;
      1: return fall0;
      2: return lvl1;
      3: return held1;
      4: return ~lvl1;
      5: return rise1;
      default: return 4'h0;
    endcase
  endfunction

  // Count rising edges until the selected signal shows any bit of mask; -1 on timeout
  task automatic wait_for(input int sel, input logic [3:0] mask, input int maxc, output int n);
    int k;
    k = 0;
    n = -1;
    repeat (maxc) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      if ((pick(sel) & mask) != 4'h0) begin
        n = k;
        break;
      end
    end
  endtask

  initial begin
    int n;
    // Reset with all buttons pressed
    rst_n  = 1'b0;
    button = 4'hF;
    step(5);
    chk("rst_outs0", int'({lvl0, rise0, fall0, held0}), 0);
    chk("rst_outs1", int'({lvl1, rise1, fall1, held1}), 0);
    rst_n  = 1'b1;
    button = 4'h0;
    step(100);
    chk("idle_lvl0", int'(lvl0), 0);

    // Clean press on ch0
    button = 4'b0001;
    wait_for(0, 4'b0001, 30, n);
    chk("rise_latency", n, 9);
    chk("rise_only_ch0", int'(rise0), 1);
    step(20);

    // Release ch0
    button = 4'b0000;
    wait_for(1, 4'b0001, 30, n);
    chk("fall_latency", n, 9);
    chk("held0_never", int'(held0[0]), 0);
    step(20);

    // Bounce on ch1, single glitch on ch2
    for (int i = 0; i < 50; i++) begin
      button[1] = ~button[1];
      step(1);
    end
    button[1] = 1'b0;
    step(20);
    chk("bounce_lvl1", int'(lvl0[1]), 0);
    button[2] = 1'b1;
    step(1);
    button[2] = 1'b0;
    step(20);
    chk("glitch_lvl2", int'({lvl0[2], lvl1[2]}), 0);

    // Long press on ch3 against the short-hold instance
    button[3] = 1'b1;
    wait_for(2, 4'b1000, 100, n);
    chk("d1_press_seen", int'(n > 0), 1);
    wait_for(3, 4'b1000, 200, n);
    chk("hold_latency", n, 64);
    step(10);
    button[3] = 1'b0;
    wait_for(4, 4'b1000, 100, n);
    chk("held_drops_with_level", int'(held1[3]), 0);
    chk("fall_pulse_d1", int'(fall1[3]), 1);
    step(50);

    // Long press on the default instance reaches its 500-tick hold
    button = 4'b0100;
    step(520);
    chk("held0_long", int'(held0[2]), 1);
    button = 4'b0000;
    step(50);

    // Simultaneous press, then reset mid-hold
    button = 4'b1001;
    wait_for(0, 4'b1001, 30, n);
    chk("simul_rise0", int'(rise0), 9);
    wait_for(5, 4'b1001, 60, n);
    chk("simul_rise1", int'(rise1), 9);
    step(70);
    rst_n = 1'b0;
    #1;
    chk("async_rst0", int'({lvl0, rise0, fall0, held0}), 0);
    chk("async_rst1", int'({lvl1, rise1, fall1, held1}), 0);
    button = 4'h0;
    step(3);
    rst_n = 1'b1;
    step(30);

    // Randomised runs and bounces
    for (int s = 0; s < 60; s++) begin
      int len;
      len = $urandom_range(1, 40);
      if ($urandom_range(0, 2) == 0) begin
        for (int i = 0; i < len; i++) begin
          button = 4'($urandom);
          step(1);
        end
      end else begin
        button = 4'($urandom);
        step(len);
      end
      if (s == 30) begin
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
      end
    end
    button = 4'h0;
    step(60);
    chk("final_idle", int'({lvl0, lvl1}), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
